// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end with an in-order fetch queue.
// Issues word-aligned fetches to instruction memory. Requests are limited by
// credits: each outstanding request reserves a queue slot. Decode pops the head
// through a valid/ready handshake. A redirect flushes the queue and marks every
// in-flight response to be dropped.
// Optional feature: define FETCH_BYPASS_EN to forward a response straight to
// decode when the queue is empty and nothing is being dropped.
module fetch_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MAX_OUTST = 2,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [6:0]  opcode_o,
    output logic [2:0]  funct3_o,
    output logic [6:0]  funct7_o,
    input  logic        decode_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUTST + 1);
    localparam int unsigned PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    logic          run_q, run_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [OW-1:0] outst_q, outst_d;
    logic [OW-1:0] drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   q_instr_q [DEPTH];
    logic [31:0]   q_instr_d [DEPTH];
    logic [31:0]   q_pc_q [DEPTH];
    logic [31:0]   q_pc_d [DEPTH];
    logic [31:0]   pend_pc_q [MAX_OUTST];
    logic [31:0]   pend_pc_d [MAX_OUTST];
    logic [PW-1:0] pend_rd_q, pend_rd_d;
    logic [PW-1:0] pend_wr_q, pend_wr_d;

    logic        fire;
    logic        head_valid;
    logic        rsp_keep;
    logic        byp_active;
    logic        push;
    logic        pop_head;
    logic [31:0] used_w;

    function automatic logic [PW-1:0] pend_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
    endfunction

    // Request issue, handshake decode and the decode-facing head outputs.
    always_comb begin
        used_w      = 32'(count_q) + 32'(outst_q);
        imem_req_o  = run_q && !redirect_i && (32'(outst_q) < MAX_OUTST) && (used_w < DEPTH);
        imem_addr_o = fetch_pc_q;
        fire        = imem_req_o && imem_gnt_i;
        head_valid  = (count_q != '0);
        rsp_keep    = imem_rvalid_i && !redirect_i && (drop_q == '0);
`ifdef FETCH_BYPASS_EN
        byp_active  = rsp_keep && !head_valid;
`else
        byp_active  = 1'b0;
`endif
        instr_valid_o = head_valid || byp_active;
        if (byp_active) begin
            instr_o = imem_rdata_i;
            pc_o    = pend_pc_q[pend_rd_q];
        end else if (head_valid) begin
            instr_o = q_instr_q[rd_ptr_q];
            pc_o    = q_pc_q[rd_ptr_q];
        end else begin
            instr_o = 32'h0;
            pc_o    = 32'h0;
        end
        pop_head = head_valid && decode_ready_i;
        // A forwarded word taken by decode in the same cycle never lands in the queue.
        push     = rsp_keep && !(byp_active && decode_ready_i);
        opcode_o = instr_o[6:0];
        funct3_o = instr_o[14:12];
        funct7_o = instr_o[31:25];
    end

    // Next-state for fetch PC, credit counters, pending-PC FIFO and queue.
    always_comb begin
        run_d      = 1'b1;
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q + OW'(fire) - OW'(imem_rvalid_i);
        drop_d     = drop_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        q_instr_d  = q_instr_q;
        q_pc_d     = q_pc_q;
        pend_pc_d  = pend_pc_q;
        pend_rd_d  = pend_rd_q;
        pend_wr_d  = pend_wr_q;
        if (redirect_i) begin
            // Every request still in flight after this edge belongs to the old path.
            fetch_pc_d = redirect_pc_i & ~32'h3;
            drop_d     = outst_q + OW'(fire) - OW'(imem_rvalid_i);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            pend_rd_d  = '0;
            pend_wr_d  = '0;
        end else begin
            if (fire) begin
                fetch_pc_d           = fetch_pc_q + 32'd4;
                pend_pc_d[pend_wr_q] = fetch_pc_q;
                pend_wr_d            = pend_inc(pend_wr_q);
            end
            if (imem_rvalid_i) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - OW'(1);
                end else begin
                    pend_rd_d = pend_inc(pend_rd_q);
                end
            end
            if (push) begin
                q_instr_d[wr_ptr_q] = imem_rdata_i;
                q_pc_d[wr_ptr_q]    = pend_pc_q[pend_rd_q];
                wr_ptr_d            = wr_ptr_q + AW'(1);
            end
            if (pop_head) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop_head);
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            run_q      <= 1'b0;
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            pend_rd_q  <= '0;
            pend_wr_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                q_instr_q[i] <= 32'h0;
                q_pc_q[i]    <= 32'h0;
            end
            for (int i = 0; i < int'(MAX_OUTST); i++) begin
                pend_pc_q[i] <= 32'h0;
            end
        end else begin
            run_q      <= run_d;
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            pend_rd_q  <= pend_rd_d;
            pend_wr_q  <= pend_wr_d;
            q_instr_q  <= q_instr_d;
            q_pc_q     <= q_pc_d;
            pend_pc_q  <= pend_pc_d;
        end
    end
endmodule
